// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO stream reader and its output buffer.
package fifo_pkg;

    localparam int unsigned DefaultDataWidth = 8;

    // Output buffer occupancy; the encoding doubles as the word count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/stream_skid_buf_2.sv
// Two-entry in-order word buffer with occupancy FSM; entry 0 is always the oldest word.
module stream_skid_buf_2
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [1:0]            count
);

    occ_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
    logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
    logic                  pop_ok;

    assign pop_ok = pop & (state_q != EMPTY);

    always_comb begin
        state_d = state_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    ent0_d  = push_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop_ok) begin
                    ent0_d = push_data;
                end else if (push) begin
                    ent1_d  = push_data;
                    state_d = TWO;
                end else if (pop_ok) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // A push without a pop cannot occur here: the reader never over-issues.
                if (pop_ok) begin
                    ent0_d = ent1_q;
                    if (push) begin
                        ent1_d = push_data;
                    end else begin
                        state_d = ONE;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            ent0_q  <= '0;
            ent1_q  <= '0;
        end else begin
            state_q <= state_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
        end
    end

    assign valid = (state_q != EMPTY);
    assign data  = ent0_q;
    assign count = state_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency synchronous FIFO into a valid/ready stream with packet framing.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned PKT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [7:0]            pkt_count
);

    logic                  inflight_q, inflight_d;
    logic [7:0]            beat_q, beat_d;
    logic [7:0]            pkt_count_q, pkt_count_d;

    logic                  buf_valid;
    logic [DATA_WIDTH-1:0] buf_data;
    logic [1:0]            buf_count;
    logic                  pop;
    logic                  beat_last;
    logic [2:0]            occ;

    stream_skid_buf_2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (fifo_data),
        .pop       (pop),
        .valid     (buf_valid),
        .data      (buf_data),
        .count     (buf_count)
    );

    assign m_valid   = buf_valid & ~rst;
    assign m_data    = rst ? '0 : buf_data;
    assign pop       = m_valid & m_ready;
    assign beat_last = (beat_q == 8'(PKT_LEN - 1));
    assign m_last    = m_valid & beat_last;
    assign pkt_count = pkt_count_q;

    // The word leaving this cycle frees its slot, which keeps back-to-back reads going.
    assign occ       = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_r_en = ~rst & en & ~fifo_empty & (occ < 3'd2);

    always_comb begin
        inflight_d  = fifo_r_en;
        beat_d      = beat_q;
        pkt_count_d = pkt_count_q;
        if (pop) begin
            if (beat_last) begin
                beat_d      = '0;
                pkt_count_d = pkt_count_q + 8'd1;
            end else begin
                beat_d = beat_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q  <= 1'b0;
            beat_q      <= '0;
            pkt_count_q <= '0;
        end else begin
            inflight_q  <= inflight_d;
            beat_q      <= beat_d;
            pkt_count_q <= pkt_count_d;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader against a 1-cycle-latency FIFO model.
module tb_fifo_stream_reader;

    localparam int PKT_LEN = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_r_en;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
    logic       m_last;
    logic [7:0] pkt_count;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .DATA_WIDTH (8),
        .PKT_LEN    (PKT_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_r_en  (fifo_r_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .pkt_count  (pkt_count)
    );

    // Upstream FIFO: words become visible once avail covers them.
    logic [7:0] mem [0:2047];
    int         wr_ptr = 0;
    int         avail  = 0;
    int         rd_ptr = 0;

    assign fifo_empty = (rd_ptr >= avail);

    always @(posedge clk) begin
        if (fifo_r_en && !fifo_empty) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] d);
        mem[wr_ptr] = d;
        wr_ptr++;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Scoreboard: every word read from the FIFO must pop out once, in order.
    logic [7:0] rd_log[$];
    int         popped     = 0;
    int         beat_m     = 0;
    int         pkt_m      = 0;
    int         last_cnt   = 0;
    bit         seen255    = 1'b0;
    bit         mon_en     = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always @(negedge clk) begin
        if (mon_en) begin
            check("no_read_when_empty", 32'(fifo_r_en & fifo_empty), 32'd0);
            check("held_plus_inflight_le_2", 32'(rd_log.size() - popped <= 2), 32'd1);
            check("pkt_count", 32'(pkt_count), 32'(pkt_m));
            check("m_last", 32'(m_last), 32'(m_valid && (beat_m == PKT_LEN - 1)));
            if (prev_stall && !rst) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", 32'(m_data), 32'(prev_data));
            end
            if (m_valid && m_ready) begin
                check("pop_has_source", 32'(popped < rd_log.size()), 32'd1);
                if (popped < rd_log.size()) begin
                    check("pop_data", 32'(m_data), 32'(rd_log[popped]));
                end
            end
            if (fifo_r_en && !fifo_empty) begin
                rd_log.push_back(mem[rd_ptr]);
            end
            if (rst) begin
                popped = rd_log.size();
                beat_m = 0;
                pkt_m  = 0;
            end else if (m_valid && m_ready) begin
                popped++;
                if (beat_m == PKT_LEN - 1) begin
                    beat_m = 0;
                    pkt_m  = (pkt_m + 1) % 256;
                    last_cnt++;
                end else begin
                    beat_m++;
                end
            end
            if (pkt_count == 8'd255) seen255 = 1'b1;
            prev_stall = m_valid && !m_ready && !rst;
            prev_data  = m_data;
        end
    end

    initial begin
        int base;
        int cyc;

        rst     = 1'b1;
        en      = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) load(8'(17 * (i + 1)));
        avail = 4;

        // Reset with a non-empty FIFO: nothing may be read or presented.
        next_cycle();
        mon_en = 1'b1;
        repeat (2) begin
            settle();
            check("rst_m_valid", 32'(m_valid), 32'd0);
            check("rst_m_last", 32'(m_last), 32'd0);
            check("rst_m_data", 32'(m_data), 32'd0);
            check("rst_fifo_r_en", 32'(fifo_r_en), 32'd0);
            check("rst_pkt_count", 32'(pkt_count), 32'd0);
            next_cycle();
        end

        // Basic packet: latency 2 from fifo_empty falling, then 1 word per cycle.
        rst   = 1'b0;
        avail = 0;
        settle();
        check("idle_m_valid", 32'(m_valid), 32'd0);
        next_cycle();
        next_cycle();
        avail = 4;
        settle();
        check("lat_t0_r_en", 32'(fifo_r_en), 32'd1);
        check("lat_t0_m_valid", 32'(m_valid), 32'd0);
        next_cycle();
        settle();
        check("lat_t1_m_valid", 32'(m_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            settle();
            check("pkt1_m_valid", 32'(m_valid), 32'd1);
            check("pkt1_m_data", 32'(m_data), 32'(17 * (i + 1)));
            check("pkt1_m_last", 32'(m_last), 32'(i == 3));
        end
        next_cycle();
        settle();
        check("pkt1_done_m_valid", 32'(m_valid), 32'd0);
        check("pkt1_done_pkt_count", 32'(pkt_count), 32'd1);

        // Backpressure: m_ready 1,0,0,1 repeating over 8 words.
        for (int i = 0; i < 8; i++) load(8'(8'hA0 + i));
        avail = wr_ptr;
        for (int c = 0; c < 48; c++) begin
            next_cycle();
            m_ready = ((c % 4) == 0) || ((c % 4) == 3);
            settle();
        end
        next_cycle();
        m_ready = 1'b1;
        repeat (3) next_cycle();
        settle();
        check("bp_popped", 32'(popped), 32'd12);
        check("bp_m_valid", 32'(m_valid), 32'd0);
        check("bp_pkt_count", 32'(pkt_count), 32'd3);

        // Empty FIFO for 20 cycles.
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            settle();
            check("empty_r_en", 32'(fifo_r_en), 32'd0);
            check("empty_m_valid", 32'(m_valid), 32'd0);
        end

        // en dropped right after a read: the in-flight word still arrives.
        for (int i = 0; i < 4; i++) load(8'(8'h51 + i));
        next_cycle();
        avail = wr_ptr;
        settle();
        check("endrop_first_r_en", 32'(fifo_r_en), 32'd1);
        next_cycle();
        en = 1'b0;
        settle();
        check("endrop_r_en_off", 32'(fifo_r_en), 32'd0);
        check("endrop_m_valid_early", 32'(m_valid), 32'd0);
        next_cycle();
        settle();
        check("endrop_inflight_valid", 32'(m_valid), 32'd1);
        check("endrop_inflight_data", 32'(m_data), 32'h51);
        next_cycle();
        settle();
        check("endrop_drained", 32'(m_valid), 32'd0);
        repeat (4) begin
            next_cycle();
            settle();
            check("endrop_hold_r_en", 32'(fifo_r_en), 32'd0);
        end
        next_cycle();
        en = 1'b1;
        repeat (8) next_cycle();
        settle();
        check("endrop_popped", 32'(popped), 32'd16);
        check("endrop_pkt_count", 32'(pkt_count), 32'd4);

        // Reset with two words buffered: both are discarded, stream restarts at beat 0.
        for (int i = 0; i < 4; i++) load(8'(8'h61 + i));
        next_cycle();
        m_ready = 1'b0;
        avail   = wr_ptr;
        repeat (3) next_cycle();
        settle();
        check("full_m_valid", 32'(m_valid), 32'd1);
        check("full_m_data", 32'(m_data), 32'h61);
        check("full_r_en", 32'(fifo_r_en), 32'd0);
        next_cycle();
        rst = 1'b1;
        settle();
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        check("midrst_m_data", 32'(m_data), 32'd0);
        check("midrst_m_last", 32'(m_last), 32'd0);
        check("midrst_r_en", 32'(fifo_r_en), 32'd0);
        next_cycle();
        rst     = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) load(8'(8'h71 + i));
        avail = wr_ptr;
        settle();
        check("postrst_m_valid", 32'(m_valid), 32'd0);
        check("postrst_pkt_count", 32'(pkt_count), 32'd0);
        check("postrst_r_en", 32'(fifo_r_en), 32'd1);
        next_cycle();
        next_cycle();
        settle();
        check("postrst_first_valid", 32'(m_valid), 32'd1);
        check("postrst_first_data", 32'(m_data), 32'h63);
        check("postrst_first_last", 32'(m_last), 32'd0);
        repeat (10) next_cycle();
        settle();
        check("postrst_pkt_count_end", 32'(pkt_count), 32'd1);
        check("postrst_idle", 32'(m_valid), 32'd0);

        // Counter wrap: 1024 beats give 256 packets and pkt_count back to 0.
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 1024; i++) load(8'(i * 7 + 3));
        base     = popped;
        last_cnt = 0;
        seen255  = 1'b0;
        avail    = wr_ptr;
        cyc      = 0;
        while ((popped - base < 1024) && (cyc < 1200)) begin
            next_cycle();
            cyc++;
        end
        repeat (2) next_cycle();
        settle();
        check("wrap_beats", 32'(popped - base), 32'd1024);
        check("wrap_last_count", 32'(last_cnt), 32'd256);
        check("wrap_seen_255", 32'(seen255), 32'd1);
        check("wrap_pkt_count", 32'(pkt_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
